id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core.
- Sits directly downstream of the register file and consumes its asynchronous rs1/rs2 read data.
- Resolves data hazards with EX/MEM and MEM/WB bypasses, then latches the operands, immediate, rd and control bundle for EX.
- Owns ecall-exit detection (x17 == 10) and the pipeline-drain sequence that raises is_halted.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 16, width of the opaque control bundle passed to EX.
- DRAIN_CYCLES, 3, accepted cycles between the exit ecall entering EX and is_halted asserting (EX, MEM, WB retire).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  ID holds a real instruction
- rs1, rs2, rd  in  5 each  register indices from the decoder
- rs1_dout, rs2_dout  in  XLEN each  register file read data
- imm  in  XLEN  sign-extended immediate
- ctrl_in  in  CTRL_W  decoded control bundle
- is_ecall  in  1  ID instruction is ecall; decoder drives rs1=17 for ecall
- stall  in  1  hold from the hazard unit
- flush  in  1  branch-mispredict squash
- exmem_rd  in  5
- exmem_reg_write  in  1
- exmem_result  in  XLEN
- memwb_rd  in  5
- memwb_reg_write  in  1
- memwb_result  in  XLEN
- valid_out  out  1
- op1_out, op2_out  out  XLEN each  resolved operands
- imm_out  out  XLEN
- rd_out  out  5
- ctrl_out  out  CTRL_W
- is_halted  out  1  machine halted; sticky until reset

Behaviour:
- Clock and reset: clk is the only clock. reset is synchronous, active-high.
- Reset values: all outputs 0; FSM in RUN; drain counter 0.
- Forwarding (combinational, before the latch), per operand:
  - EX/MEM match wins when exmem_reg_write, exmem_rd != 0 and exmem_rd == rsN.
  - Otherwise MEM/WB match applies under the same rules using the memwb_* ports.
  - Otherwise rsN_dout is used.
  - Index 0 never forwards. MEM/WB forwarding covers the same-cycle register file write, which async read cannot see.
- Latch, evaluated in priority order each rising edge:
  1. reset.
  2. flush: bubble, i.e. valid_out=0 and ctrl_out=0; data fields don't-care but driven 0. flush beats stall.
  3. stall: all outputs hold.
  4. Otherwise: capture inputs; valid_out=valid_in.
- Latency: 1 cycle from ID inputs to outputs.
- Exit condition: an instruction is accepted when valid_in & !stall & !flush & state==RUN. The exit condition is an accepted instruction with is_ecall=1 and forwarded op1 == 10.
- FSM:
  - RUN: on the exit condition, latch the ecall normally, load counter with DRAIN_CYCLES, go to DRAIN.
  - DRAIN:
    - Every non-flush capture is forced to a bubble; no further instructions enter EX.
    - Counter decrements on each cycle with !stall.
    - When counter==1 and !stall, go to HALTED.
    - flush in DRAIN is ignored for state; the ecall is already past ID.
  - HALTED: is_halted=1, outputs are bubbles, stays until reset.
- Non-exit ecall (op1 != 10): passes as a normal instruction; no state change.
- Reset mid-DRAIN or in HALTED: returns to RUN with is_halted=0 on the next edge.
- Widths: no arithmetic besides the counter (clog2(DRAIN_CYCLES+1) bits, no wrap; saturates at 0).

Optional Feature:
- Macro: ID_EX_BYPASS_EN.
- Defined: forwarding as above.
- Undefined: op1/op2 come straight from rs1_dout/rs2_dout, and the exmem_*/memwb_* ports are ignored. The hazard unit must stall on every RAW hazard. The exit check uses the unforwarded rs1_dout.

Decomposition:
- Shared package cpu_pkg:
  - XLEN.
  - ECALL_EXIT_CODE=10.
  - REG_X17=17.
  - halt FSM state enum {RUN, DRAIN, HALTED}.
  - Control-bundle field typedef.
- One sub-module, operand_forward: a pure combinational per-operand 3-way select, instantiated twice.

Test Plan:
- Forward priority: exmem_rd=5 / exmem_result=0xAAAA and memwb_rd=5 / memwb_result=0xBBBB, both writing, rs1=5 -> op1_out=0xAAAA one cycle later.
- x0 guard: exmem_rd=0 / exmem_result=0xDEAD, rs2=0, rs2_dout=0 -> op2_out=0.
- Stall vs flush: latch valid instruction A, then stall=1 for 2 cycles -> outputs hold A. Assert stall=1 and flush=1 together -> valid_out=0, ctrl_out=0.
- Exit ecall: x17 forwarded 10 from MEM/WB, is_ecall=1 -> valid ecall at outputs, then 3 bubble cycles, then is_halted=1 and sticky. One stall during DRAIN delays is_halted by exactly 1 cycle.
- Non-exit ecall: rs1_dout=3 -> no DRAIN, is_halted stays 0.
- Reset in DRAIN after 1 cycle -> next edge state RUN, is_halted=0, outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the RV32I pipeline: widths, ecall-exit code,
// halt FSM states and the EX control-bundle layout.
package cpu_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned CTRL_W          = 16;
  localparam int unsigned DRAIN_CYCLES    = 3;
  localparam logic [31:0] ECALL_EXIT_CODE = 32'd10;
  localparam logic [4:0]  REG_X17         = 5'd17;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_e;

  // Field view of the CTRL_W-bit bundle; ID/EX itself treats it as opaque.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic [4:0] rsvd;
  } ctrl_fields_t;

endpackage

// File: rtl/operand_forward.sv
// Per-operand bypass select: EX/MEM beats MEM/WB beats register file; x0 never forwards.
module operand_forward
  import cpu_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [4:0]   rs,
  input  logic [W-1:0] rf_data,
  input  logic [4:0]   exmem_rd,
  input  logic         exmem_reg_write,
  input  logic [W-1:0] exmem_result,
  input  logic [4:0]   memwb_rd,
  input  logic         memwb_reg_write,
  input  logic [W-1:0] memwb_result,
  output logic [W-1:0] operand
);

  always_comb begin
    operand = rf_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
      operand = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
      operand = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, ecall-exit detection and halt drain.
// Bypass network is built only when ID_EX_BYPASS_EN is defined.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN         = cpu_pkg::XLEN,
  parameter int unsigned CTRL_W       = cpu_pkg::CTRL_W,
  parameter int unsigned DRAIN_CYCLES = cpu_pkg::DRAIN_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [XLEN-1:0]   rs1_dout,
  input  logic [XLEN-1:0]   rs2_dout,
  input  logic [XLEN-1:0]   imm,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              is_ecall,
  input  logic              stall,
  input  logic              flush,
  input  logic [4:0]        exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [4:0]        memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              valid_out,
  output logic [XLEN-1:0]   op1_out,
  output logic [XLEN-1:0]   op2_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [4:0]        rd_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              is_halted
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);

  logic [XLEN-1:0] op1_fwd, op2_fwd;
  halt_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept, exit_hit;

`ifdef ID_EX_BYPASS_EN
  operand_forward #(.W(XLEN)) u_fwd_op1 (
    .rs              (rs1),
    .rf_data         (rs1_dout),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .operand         (op1_fwd)
  );

  operand_forward #(.W(XLEN)) u_fwd_op2 (
    .rs              (rs2),
    .rf_data         (rs2_dout),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .operand         (op2_fwd)
  );
`else
  // Hazard unit stalls on every RAW hazard, so the bypass inputs carry nothing we need.
  logic unused_bypass_ports;
  assign unused_bypass_ports = ^{exmem_rd, exmem_reg_write, exmem_result,
                                 memwb_rd, memwb_reg_write, memwb_result, rs1, rs2};
  assign op1_fwd = rs1_dout;
  assign op2_fwd = rs2_dout;
`endif

  assign accept   = valid_in && !stall && !flush && (state_q == RUN);
  assign exit_hit = accept && is_ecall && (op1_fwd == XLEN'(ECALL_EXIT_CODE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (exit_hit) begin
          state_d = DRAIN;
          cnt_d   = CntW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        // flush is irrelevant here: the ecall is already downstream of ID.
        if (!stall) begin
          if (cnt_q <= CntW'(1)) begin
            state_d = HALTED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && (state_q != RUN))) begin
      valid_out <= 1'b0;
      op1_out   <= '0;
      op2_out   <= '0;
      imm_out   <= '0;
      rd_out    <= '0;
      ctrl_out  <= '0;
    end else if (!stall) begin
      valid_out <= valid_in;
      op1_out   <= op1_fwd;
      op2_out   <= op2_fwd;
      imm_out   <= imm;
      rd_out    <= rd;
      ctrl_out  <= ctrl_in;
    end
  end

  assign is_halted = (state_q == HALTED);

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, directed halt/stall/flush
// sequences and a randomized run against a behavioural model.
module tb_id_ex_stage;

`ifdef ID_EX_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif
  localparam int DrainN = 3;

  logic        clk, reset, valid_in, is_ecall, stall, flush;
  logic [4:0]  rs1, rs2, rd, exmem_rd, memwb_rd;
  logic [31:0] rs1_dout, rs2_dout, imm, exmem_result, memwb_result;
  logic [15:0] ctrl_in;
  logic        exmem_reg_write, memwb_reg_write;
  logic        valid_out, is_halted;
  logic [31:0] op1_out, op2_out, imm_out;
  logic [4:0]  rd_out;
  logic [15:0] ctrl_out;

  id_ex_stage dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .rs1             (rs1),
    .rs2             (rs2),
    .rd              (rd),
    .rs1_dout        (rs1_dout),
    .rs2_dout        (rs2_dout),
    .imm             (imm),
    .ctrl_in         (ctrl_in),
    .is_ecall        (is_ecall),
    .stall           (stall),
    .flush           (flush),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .valid_out       (valid_out),
    .op1_out         (op1_out),
    .op2_out         (op2_out),
    .imm_out         (imm_out),
    .rd_out          (rd_out),
    .ctrl_out        (ctrl_out),
    .is_halted       (is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; valid_in = 0; is_ecall = 0; stall = 0; flush = 0;
    rs1 = 0; rs2 = 0; rd = 0; rs1_dout = 0; rs2_dout = 0; imm = 0; ctrl_in = 0;
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid, m_halted;
  logic [31:0] m_op1, m_op2, m_imm;
  logic [4:0]  m_rd;
  logic [15:0] m_ctrl;
  int          m_drain;  // edges left before halt; 0 when not draining

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] dout);
    if (!Byp) return dout;
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
    return dout;
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0; m_ctrl = 0;
  endtask

  task automatic model_edge();
    bit running;
    logic [31:0] f1, f2;
    if (reset) begin
      model_bubble();
      m_halted = 0;
      m_drain  = 0;
      return;
    end
    running = !m_halted && m_drain == 0;
    f1 = fwd(rs1, rs1_dout);
    f2 = fwd(rs2, rs2_dout);
    if (flush) model_bubble();
    else if (stall) begin end
    else if (!running) model_bubble();
    else begin
      m_valid = valid_in; m_op1 = f1; m_op2 = f2; m_imm = imm; m_rd = rd; m_ctrl = ctrl_in;
    end
    if (m_drain > 0) begin
      if (!stall) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end
    end else if (running && valid_in && !stall && !flush && is_ecall && f1 == 32'd10) begin
      m_drain = DrainN;
    end
  endtask

  task automatic check_model(input int cyc);
    check($sformatf("rnd%0d.valid", cyc), 32'(valid_out), 32'(m_valid));
    check($sformatf("rnd%0d.op1", cyc), op1_out, m_op1);
    check($sformatf("rnd%0d.op2", cyc), op2_out, m_op2);
    check($sformatf("rnd%0d.imm", cyc), imm_out, m_imm);
    check($sformatf("rnd%0d.rd", cyc), 32'(rd_out), 32'(m_rd));
    check($sformatf("rnd%0d.ctrl", cyc), 32'(ctrl_out), 32'(m_ctrl));
    check($sformatf("rnd%0d.halted", cyc), 32'(is_halted), 32'(m_halted));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [4:0]  r1, r2, er, mr;
    logic [31:0] d1, d2, ed, md;
    logic        ew, mw;
    logic [31:0] e1, e2;
  } vec_t;

  function automatic vec_t mkv(input logic v, input logic [4:0] r1, input logic [31:0] d1,
                               input logic [4:0] r2, input logic [31:0] d2,
                               input logic [4:0] er, input logic ew, input logic [31:0] ed,
                               input logic [4:0] mr, input logic mw, input logic [31:0] md,
                               input logic [31:0] e1, input logic [31:0] e2);
    vec_t t;
    t.v = v; t.r1 = r1; t.d1 = d1; t.r2 = r2; t.d2 = d2;
    t.er = er; t.ew = ew; t.ed = ed; t.mr = mr; t.mw = mw; t.md = md;
    t.e1 = e1; t.e2 = e2;
    return t;
  endfunction

  vec_t vecs[6];

  initial begin
    // EX/MEM beats MEM/WB on the same register
    vecs[0] = mkv(1, 5, 32'h1111, 6, 32'h2222, 5, 1, 32'hAAAA, 5, 1, 32'hBBBB,
                  Byp ? 32'hAAAA : 32'h1111, 32'h2222);
    // x0 never forwards; rs1 picks MEM/WB
    vecs[1] = mkv(1, 3, 32'h33, 0, 32'h0, 0, 1, 32'hDEAD, 3, 1, 32'h3333,
                  Byp ? 32'h3333 : 32'h33, 32'h0);
    // MEM/WB applies to both operands when EX/MEM targets another reg
    vecs[2] = mkv(1, 7, 32'h77, 7, 32'h78, 8, 1, 32'h8888, 7, 1, 32'hCAFE,
                  Byp ? 32'hCAFE : 32'h77, Byp ? 32'hCAFE : 32'h78);
    // matching rd but no write enable
    vecs[3] = mkv(1, 9, 32'h900, 9, 32'h901, 9, 0, 32'h99, 9, 0, 32'h98, 32'h900, 32'h901);
    // invalid slot still captures data
    vecs[4] = mkv(0, 1, 32'h10, 2, 32'h20, 0, 0, 32'h0, 0, 0, 32'h0, 32'h10, 32'h20);
    // op2 from EX/MEM, op1 from MEM/WB
    vecs[5] = mkv(1, 4, 32'h40, 12, 32'h120, 12, 1, 32'h1200, 4, 1, 32'h4000,
                  Byp ? 32'h4000 : 32'h40, Byp ? 32'h1200 : 32'h120);

    idle();
    reset = 1;
    step();
    check("reset.valid", 32'(valid_out), 32'd0);
    check("reset.op1", op1_out, 32'd0);
    check("reset.op2", op2_out, 32'd0);
    check("reset.ctrl", 32'(ctrl_out), 32'd0);
    check("reset.rd", 32'(rd_out), 32'd0);
    check("reset.halted", 32'(is_halted), 32'd0);
    reset = 0;

    for (int i = 0; i < 6; i++) begin
      idle();
      valid_in = vecs[i].v; rs1 = vecs[i].r1; rs1_dout = vecs[i].d1;
      rs2 = vecs[i].r2; rs2_dout = vecs[i].d2;
      exmem_rd = vecs[i].er; exmem_reg_write = vecs[i].ew; exmem_result = vecs[i].ed;
      memwb_rd = vecs[i].mr; memwb_reg_write = vecs[i].mw; memwb_result = vecs[i].md;
      rd = 5'(i + 1); imm = 32'h1000 + 32'(i); ctrl_in = 16'h00A0 + 16'(i);
      step();
      check($sformatf("vec%0d.op1", i), op1_out, vecs[i].e1);
      check($sformatf("vec%0d.op2", i), op2_out, vecs[i].e2);
      check($sformatf("vec%0d.valid", i), 32'(valid_out), 32'(vecs[i].v));
      check($sformatf("vec%0d.rd", i), 32'(rd_out), 32'(i + 1));
      check($sformatf("vec%0d.imm", i), imm_out, 32'h1000 + 32'(i));
      check($sformatf("vec%0d.ctrl", i), 32'(ctrl_out), 32'h00A0 + 32'(i));
    end

    // stall holds, flush beats stall
    idle();
    valid_in = 1; rs1 = 2; rs1_dout = 32'h1234_5678; rs2 = 3; rs2_dout = 32'h0BAD_F00D;
    imm = 32'h55; rd = 4; ctrl_in = 16'h00C3;
    step();
    check("sf.capture.valid", 32'(valid_out), 32'd1);
    stall = 1; rs1_dout = 32'hFFFF_FFFF; ctrl_in = 16'hFFFF; rd = 31; imm = 32'h1;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("sf.hold%0d.op1", k), op1_out, 32'h1234_5678);
      check($sformatf("sf.hold%0d.op2", k), op2_out, 32'h0BAD_F00D);
      check($sformatf("sf.hold%0d.rd", k), 32'(rd_out), 32'd4);
      check($sformatf("sf.hold%0d.ctrl", k), 32'(ctrl_out), 32'h00C3);
      check($sformatf("sf.hold%0d.valid", k), 32'(valid_out), 32'd1);
    end
    flush = 1;
    step();
    check("sf.flush.valid", 32'(valid_out), 32'd0);
    check("sf.flush.ctrl", 32'(ctrl_out), 32'd0);
    check("sf.flush.op1", op1_out, 32'd0);

    // exit ecall with one stall during the drain
    idle();
    reset = 1; step(); reset = 0;
    valid_in = 1; is_ecall = 1; rs1 = 17; rs1_dout = Byp ? 32'd0 : 32'd10;
    memwb_rd = 17; memwb_reg_write = 1; memwb_result = 32'd10; ctrl_in = 16'h0F00;
    step();
    check("exit.ecall.valid", 32'(valid_out), 32'd1);
    check("exit.ecall.ctrl", 32'(ctrl_out), 32'h0F00);
    check("exit.ecall.op1", op1_out, 32'd10);
    check("exit.ecall.halted", 32'(is_halted), 32'd0);
    idle();
    valid_in = 1; rs1 = 1; rs1_dout = 32'h5; ctrl_in = 16'h1234; rd = 9;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("exit.drain%0d.valid", k), 32'(valid_out), 32'd0);
      check($sformatf("exit.drain%0d.ctrl", k), 32'(ctrl_out), 32'd0);
      check($sformatf("exit.drain%0d.halted", k), 32'(is_halted), 32'd0);
    end
    stall = 1;
    step();
    check("exit.stalled.halted", 32'(is_halted), 32'd0);
    stall = 0;
    step();
    check("exit.halt.halted", 32'(is_halted), 32'd1);
    check("exit.halt.valid", 32'(valid_out), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("exit.sticky%0d.halted", k), 32'(is_halted), 32'd1);
      check($sformatf("exit.sticky%0d.valid", k), 32'(valid_out), 32'd0);
    end

    // non-exit ecall passes through
    idle();
    reset = 1; step(); reset = 0;
    valid_in = 1; is_ecall = 1; rs1 = 17; rs1_dout = 32'd3; ctrl_in = 16'h0F01;
    step();
    check("noexit.ecall.valid", 32'(valid_out), 32'd1);
    check("noexit.ecall.op1", op1_out, 32'd3);
    is_ecall = 0; ctrl_in = 16'h0042;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("noexit.after%0d.valid", k), 32'(valid_out), 32'd1);
      check($sformatf("noexit.after%0d.halted", k), 32'(is_halted), 32'd0);
    end

    // reset one cycle into the drain
    idle();
    valid_in = 1; is_ecall = 1; rs1 = 17; rs1_dout = 32'd10; ctrl_in = 16'h0F02; rd = 3;
    step();
    idle();
    step();
    check("rstdrain.bubble.valid", 32'(valid_out), 32'd0);
    reset = 1;
    step();
    reset = 0;
    check("rstdrain.halted", 32'(is_halted), 32'd0);
    check("rstdrain.valid", 32'(valid_out), 32'd0);
    check("rstdrain.op1", op1_out, 32'd0);
    check("rstdrain.ctrl", 32'(ctrl_out), 32'd0);
    valid_in = 1; rs1 = 6; rs1_dout = 32'h66; ctrl_in = 16'h0077;
    step();
    check("rstdrain.run.valid", 32'(valid_out), 32'd1);
    check("rstdrain.run.ctrl", 32'(ctrl_out), 32'h0077);

    // randomized run against the model
    idle();
    reset = 1;
    model_edge();
    step();
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 63) == 0);
      valid_in        = ($urandom_range(0, 3) != 0);
      is_ecall        = ($urandom_range(0, 5) == 0);
      stall           = ($urandom_range(0, 3) == 0);
      flush           = ($urandom_range(0, 7) == 0);
      rs1             = ($urandom_range(0, 4) == 0) ? 5'd17 : 5'($urandom_range(0, 3));
      rs2             = 5'($urandom_range(0, 3));
      rd              = 5'($urandom);
      rs1_dout        = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom;
      rs2_dout        = $urandom;
      imm             = $urandom;
      ctrl_in         = 16'($urandom);
      exmem_rd        = ($urandom_range(0, 4) == 0) ? 5'd17 : 5'($urandom_range(0, 3));
      exmem_reg_write = 1'($urandom);
      exmem_result    = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom;
      memwb_rd        = ($urandom_range(0, 4) == 0) ? 5'd17 : 5'($urandom_range(0, 3));
      memwb_reg_write = 1'($urandom);
      memwb_result    = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom;
      model_edge();
      step();
      check_model(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
